// File: rtl/seg7_mux_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Shared active-low seg/dp bus and one active-low anode per digit. Digit data
// is double buffered: loads land in a shadow buffer, and the display buffer
// only takes the shadow contents at a frame boundary, so a frame never tears.
// Each digit slot opens with a short all-anodes-off window to hide ghosting.
// All pin outputs are registered, one cycle behind the scan counters.
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } slot_state_e;

  // With no blank window every slot starts straight in DRIVE.
  localparam slot_state_e RESET_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  slot_state_e             state_q, state_d;
  logic                    cnt_wrap;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    all_zero;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_lz;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  // Segment pattern for one BCD digit; codes above 9 show nothing.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign frame_end = cnt_wrap && (idx_q == IDX_LAST);

  // Prescaler and digit index: idx steps once per slot, wrapping after the last digit.
  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Slot FSM next state: state_q always describes the slot phase of the current cnt_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BLANK: if (cnt_d >= CNT_BLANK) state_d = S_DRIVE;
      S_DRIVE: if (cnt_wrap && (BLANK_CYCLES > 0)) state_d = S_BLANK;
      default: state_d = RESET_STATE;
    endcase
  end

  // Scan counters and slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= RESET_STATE;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Double buffer: a load coincident with frame end bypasses straight into the display buffer.
  always_comb begin
    shadow_bcd_d = load ? bcd   : shadow_bcd_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    disp_bcd_d   = frame_end ? shadow_bcd_d : disp_bcd_q;
    disp_dp_d    = frame_end ? shadow_dp_d  : disp_dp_q;
  end

  // Shadow and display buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
    end else begin
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  // Leading-zero mask: digit i is a leading zero when it and every higher digit are 0; digit 0 never is.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (disp_bcd_q[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  // Pick the display digit, dp bit and blank flag for the current index, and form the next pin values.
  always_comb begin
    cur_digit    = 4'd0;
    cur_dp       = 1'b0;
    cur_lz       = 1'b0;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;
    an_d         = '1;
    frame_done_d = frame_end;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = disp_bcd_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_lz    = lz_mask[i];
        if (state_q == S_DRIVE) an_d[i] = 1'b0;
      end
    end
    if (state_q == S_DRIVE) begin
      seg_d = ((LZ_BLANK != 0) && blank_en && cur_lz) ? 7'b1111111 : decode(cur_digit);
      dp_d  = ~cur_dp;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver with 4 digits, 4-cycle slots, 1 blank cycle.
// Timeline: cyc counts clock edges since reset release. The pins seen after
// edge k reflect scan position k-1, so frame n is lit at cyc 16n+4d+c+1
// (digit d, c = 1..3) and frame_done is seen at cyc 16n for n >= 1.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int cyc;

  // Expected entry: {cyc[15:0], an[3:0], seg[6:0], dp}
  logic [27:0] exp_q[$];

  seg7_mux_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1),
    .LZ_BLANK    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd       (bcd),
    .dp_in     (dp_in),
    .load      (load),
    .blank_en  (blank_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  // Clock and bench cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  // Queue the 12 lit cycles of frame n; s3..s0 are hand-computed segment codes.
  task automatic push_frame(input int n, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpi);
    logic [6:0] s;
    logic [3:0] a;
    int k;
    for (int d = 0; d < 4; d++) begin
      s = (d == 0) ? s0 : (d == 1) ? s1 : (d == 2) ? s2 : s3;
      a = 4'hF;
      a[d] = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        k = 16 * n + 4 * d + c + 1;
        exp_q.push_back({k[15:0], a, s, ~dpi[d]});
      end
    end
  endtask

  // Driver tasks: inputs change 1 time unit after edge k, so the DUT sees them at edge k+1.
  task automatic wait_to(input int k);
    while (cyc != k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_at(input int k, input logic [15:0] v, input logic [3:0] d);
    wait_to(k);
    bcd = v;
    dp_in = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    chk({tag, "_dp"}, {31'd0, dp}, 32'h1);
    chk({tag, "_an"}, {28'd0, an}, 32'hF);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'h0);
  endtask

  // Monitor: every lit cycle pops one expected entry; dark cycles must be fully blank.
  always @(negedge clk) begin
    logic [27:0] e;
    logic        fd_exp;
    fd_exp = (cyc != 0) && (cyc % 16 == 0);
    chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
    if (an != 4'hF) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drive_unexpected: got an=%b seg=%b dp=%b want no lit digit (cyc %0d)", an, seg, dp, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("drive", {4'd0, cyc[15:0], an, seg, dp}, {4'd0, e});
      end
    end else begin
      chk("dark_slot", {24'd0, seg, dp}, 32'hFF);
    end
  end

  // Watchdog
  initial begin
    #5000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Directed stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: buffers cleared by reset, all digits show 0.
    push_frame(0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0000);
    // Frame 1: 1234 loaded mid frame 0.
    push_frame(1, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b0000);
    load_at(4, 16'h1234, 4'b0000);

    // Frame 2: two loads during frame 1; frame 1 keeps 1234, last load 5678 wins.
    push_frame(2, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 4'b0000);
    load_at(19, 16'h9999, 4'b0000);
    load_at(25, 16'h5678, 4'b0000);

    // Frame 3: 0070 with leading-zero suppression.
    push_frame(3, 7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001, 4'b0000);
    load_at(35, 16'h0070, 4'b0000);
    wait_to(48);
    blank_en = 1'b1;

    // Frame 4: same buffer, suppression off.
    push_frame(4, 7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001, 4'b0000);
    wait_to(64);
    blank_en = 1'b0;

    // Frame 5: invalid digit A with its decimal point lit.
    push_frame(5, 7'b0000001, 7'b0000001, 7'b1111111, 7'b0000001, 4'b0010);
    load_at(70, 16'h00A0, 4'b0010);

    // Frame 6: mid-frame 1111 overridden by a load coincident with frame end.
    push_frame(6, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100, 4'b0101);
    load_at(84, 16'h1111, 4'b1111);
    load_at(95, 16'h8765, 4'b0101);

    // Frame 7: only the first lit cycle of digit 0 happens before reset hits.
    exp_q.push_back({16'd114, 4'b1110, 7'b0100100, 1'b0});
    wait_to(115);
    rst_n = 1'b0;
    #1;
    check_reset_pins("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart: buffers cleared again, scan starts at digit 0.
    push_frame(0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b0000);
    wait_to(17);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
